// File: rtl/bcd_to_binary_seq.sv
// ============================================================================
//  Module   : bcd_to_binary_seq
//  Purpose  : Iterative packed-BCD to binary converter, one digit per clock,
//             MSD first, with invalid-digit and overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_to_binary_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      binary,
    output logic                  err_digit,
    output logic                  ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;
    logic [BIN_W-1:0]   r_binary;
    logic               r_err_digit;
    logic               r_ovf;

    logic [3:0]         w_nib;
    logic               w_nib_bad;
    logic               w_last;
    logic [ACC_W-1:0]   w_acc_next;
    logic [BIN_W-1:0]   w_bin_next;
    logic               w_ovf_next;

    assign w_nib      = r_shift[ACC_W-1 -: 4];
    assign w_nib_bad  = (w_nib > 4'd9);
    assign w_last     = (r_cnt == CNT_W'(DIGITS - 1));
    // acc*10 as shift-and-add; ACC_W bits always hold the full result
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + ACC_W'(w_nib);

    generate
        if (BIN_W >= ACC_W) begin : g_wide
            assign w_bin_next = BIN_W'(w_acc_next);
            assign w_ovf_next = 1'b0;
        end else begin : g_narrow
            assign w_bin_next = w_acc_next[BIN_W-1:0];
            assign w_ovf_next = |w_acc_next[ACC_W-1:BIN_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_CONV;
                end
            end
            S_CONV: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_binary    <= '0;
            r_err_digit <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift <= bcd_in;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_CONV: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift << 4;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_nib_bad) begin
                        r_err <= 1'b1;
                    end
                    if (w_last) begin
                        r_binary    <= w_bin_next;
                        r_ovf       <= w_ovf_next;
                        r_err_digit <= r_err | w_nib_bad;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign binary    = r_binary;
    assign err_digit = r_err_digit;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire
